mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit. Consumes the EX/MEM pipeline register outputs and runs the
//  req/gnt/rvalid handshake to data memory. Stalls the pipeline until the access completes,

---
 rtl/mem_stage_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives the data-memory req/gnt/rvalid handshake
// from the EX/MEM register, stalls the pipeline until the access finishes,
// and loads the MEM/WB register with the ALU result or the extended load data.
// Misaligned accesses and bus timeouts raise a one-cycle mem_fault pulse.

module mem_stage_lsu #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_store_data,
    input  logic [4:0]  mem_rd,
    input  logic [2:0]  mem_funct3,
    input  logic        mem_regwrite,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic        mem_memtoreg,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        mem_fault
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]       size;
    logic [1:0]       ofs;
    logic             op;
    logic             misaligned;
    logic             tmo_hit;

    // Byte enables for an access of the given size at byte offset o.
    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] o);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << o;
            SZ_H:    be = 4'b0011 << o;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate LSB-aligned store data into every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] sd);
        logic [31:0] wd;
        case (sz)
            SZ_B:    wd = {4{sd[7:0]}};
            SZ_H:    wd = {2{sd[15:0]}};
            default: wd = sd;
        endcase
        return wd;
    endfunction

    // Shift the addressed lane down and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] o,
                                                input logic [1:0] sz, input logic uns);
        logic        [31:0] shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic        [31:0] res;
        shifted = rdata >> {o, 3'b000};
        b       = $signed(shifted[7:0]);
        h       = $signed(shifted[15:0]);
        case (sz)
            SZ_B:    res = uns ? {24'h0, shifted[7:0]}  : {{24{b[7]}}, b};
            SZ_H:    res = uns ? {16'h0, shifted[15:0]} : {{16{h[15]}}, h};
            default: res = shifted;
        endcase
        return res;
    endfunction

    // Access size from funct3; unknown encodings behave as a word access.
    always_comb begin
        case (mem_funct3)
            3'b000, 3'b100: size = SZ_B;
            3'b001, 3'b101: size = SZ_H;
            default:        size = SZ_W;
        endcase
    end

    assign ofs        = mem_alu_result[1:0];
    assign op         = mem_memread | mem_memwrite;
    assign misaligned = ((size == SZ_H) && ofs[0]) || ((size == SZ_W) && (ofs != 2'b00));
    assign tmo_hit    = (state != S_IDLE) && (tmo_cnt == TMO_LAST);

    assign dmem_we    = mem_memwrite;
    assign dmem_addr  = {mem_alu_result[31:2], 2'b00};
    assign dmem_be    = lane_be(size, ofs);
    assign dmem_wdata = lane_wdata(size, mem_store_data);

    // Handshake request and pipeline stall; a store completes in its grant cycle.
    always_comb begin
        dmem_req = 1'b0;
        stall    = 1'b0;
        case (state)
            S_IDLE: begin
                if (op && !misaligned) begin
                    dmem_req = 1'b1;
                    stall    = !(dmem_gnt && mem_memwrite);
                end
            end
            S_REQ: begin
                if (!tmo_hit) begin
                    dmem_req = 1'b1;
                    stall    = !(dmem_gnt && mem_memwrite);
                end
            end
            S_RESP:  stall = !(dmem_rvalid || tmo_hit);
            default: ;
        endcase
        if (rst) begin
            dmem_req = 1'b0;
            stall    = 1'b0;
        end
    end

    // Access FSM, timeout counter and MEM/WB register (bubble while stalled).
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            wb_result   <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            mem_fault   <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    if (!op) begin
                        wb_result   <= mem_alu_result;
                        wb_rd       <= mem_rd;
                        wb_regwrite <= mem_regwrite;
                    end else if (misaligned) begin
                        wb_rd       <= mem_rd;
                        wb_regwrite <= 1'b0;
                        mem_fault   <= 1'b1;
                    end else begin
                        wb_regwrite <= 1'b0;
                        if (dmem_gnt && mem_memwrite) begin
                            wb_rd <= mem_rd;
                        end else if (dmem_gnt) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    wb_regwrite <= 1'b0;
                    if (tmo_hit) begin
                        state     <= S_IDLE;
                        tmo_cnt   <= '0;
                        wb_rd     <= mem_rd;
                        mem_fault <= 1'b1;
                    end else if (dmem_gnt && mem_memwrite) begin
                        state   <= S_IDLE;
                        tmo_cnt <= '0;
                        wb_rd   <= mem_rd;
                    end else begin
                        if (dmem_gnt) begin
                            state <= S_RESP;
                        end
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        wb_result   <= mem_memtoreg
                                       ? load_extend(dmem_rdata, ofs, size, mem_funct3[2])
                                       : mem_alu_result;
                        wb_rd       <= mem_rd;
                        wb_regwrite <= mem_regwrite;
                        state       <= S_IDLE;
                        tmo_cnt     <= '0;
                    end else if (tmo_hit) begin
                        wb_rd       <= mem_rd;
                        wb_regwrite <= 1'b0;
                        mem_fault   <= 1'b1;
                        state       <= S_IDLE;
                        tmo_cnt     <= '0;
                    end else begin
                        wb_regwrite <= 1'b0;
                        tmo_cnt     <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: a per-op memory responder with
// programmable grant/response delays, a reference model for lanes and load
// extension, and a scoreboard queue of expected MEM/WB contents.

`timescale 1ns/1ps

module tb_mem_stage_lsu;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic        mem_regwrite;
    logic        mem_memread;
    logic        mem_memwrite;
    logic        mem_memtoreg;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        mem_fault;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        flt;
        bit          chk_res;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int      checks = 0;
    int      errors = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_funct3     (mem_funct3),
        .mem_regwrite   (mem_regwrite),
        .mem_memread    (mem_memread),
        .mem_memwrite   (mem_memwrite),
        .mem_memtoreg   (mem_memtoreg),
        .stall          (stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .wb_result      (wb_result),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .mem_fault      (mem_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] o);
        case (f3)
            3'b000, 3'b100: begin
                case (o)
                    2'd0:    return 4'b0001;
                    2'd1:    return 4'b0010;
                    2'd2:    return 4'b0100;
                    default: return 4'b1000;
                endcase
            end
            3'b001, 3'b101: return o[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'b000, 3'b100: return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            3'b001, 3'b101: return {sd[15:0], sd[15:0]};
            default:        return sd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h000000, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0000, h};
            default: return w;
        endcase
    endfunction

    // One EX/MEM op: gwait = grant-low cycles, rwait = response wait (<0: never).
    task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                          input logic mr, input logic mw, input int gwait, input int rwait,
                          input logic [31:0] rdata, input int exp_req, input int exp_stall,
                          input bit exp_flt, input bit stray_rv);
        wb_exp_t e;
        wb_exp_t got;
        int      req_n;
        int      stall_n;
        int      gl;
        int      rl;
        int      cyc;
        bit      granted;
        bit      done;
        if (!(mr || mw))  e = '{res: alu, rd: rd, rw: rw, flt: 1'b0, chk_res: 1'b1};
        else if (exp_flt) e = '{res: 32'h0, rd: rd, rw: 1'b0, flt: 1'b1, chk_res: 1'b0};
        else if (mw)      e = '{res: 32'h0, rd: rd, rw: 1'b0, flt: 1'b0, chk_res: 1'b0};
        else              e = '{res: m_load(f3, alu[1:0], rdata), rd: rd, rw: rw,
                                flt: 1'b0, chk_res: 1'b1};
        exp_q.push_back(e);

        @(negedge clk);
        mem_alu_result = alu;
        mem_store_data = sd;
        mem_rd         = rd;
        mem_funct3     = f3;
        mem_regwrite   = rw;
        mem_memread    = mr;
        mem_memwrite   = mw;
        mem_memtoreg   = mr;
        req_n   = 0;
        stall_n = 0;
        gl      = gwait;
        rl      = rwait;
        cyc     = 0;
        granted = 1'b0;
        done    = 1'b0;
        while (!done) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = stray_rv;
            dmem_rdata  = 32'h5EED_0000;
            #1;
            if (dmem_req) begin
                req_n++;
                if (gl == 0) begin
                    dmem_gnt = 1'b1;
                    check({tag, "_be"},    {28'h0, dmem_be}, {28'h0, m_be(f3, alu[1:0])});
                    check({tag, "_wdata"}, dmem_wdata, m_wdata(f3, sd));
                    check({tag, "_addr"},  dmem_addr, {alu[31:2], 2'b00});
                    check({tag, "_we"},    {31'h0, dmem_we}, {31'h0, mw});
                    if (!mw) granted = 1'b1;
                end else begin
                    gl--;
                end
            end else if (granted && rwait >= 0) begin
                if (rl == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end else begin
                    rl--;
                end
            end
            #1;
            if (stall) stall_n++;
            else       done = 1'b1;
            cyc++;
            if (!done) begin
                if (cyc >= 200) begin
                    check({tag, "_bound"}, cyc, 0);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        check({tag, "_reqcyc"},   req_n, exp_req);
        check({tag, "_stallcyc"}, stall_n, exp_stall);

        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            got = exp_q.pop_front();
            if (got.chk_res) check({tag, "_wb_result"}, wb_result, got.res);
            check({tag, "_wb_rd"},    {27'h0, wb_rd}, {27'h0, got.rd});
            check({tag, "_wb_rw"},    {31'h0, wb_regwrite}, {31'h0, got.rw});
            check({tag, "_fault"},    {31'h0, mem_fault}, {31'h0, got.flt});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        mem_alu_result = 32'h0;
        mem_store_data = 32'h0;
        mem_rd         = 5'd0;
        mem_funct3     = 3'b000;
        mem_regwrite   = 1'b0;
        mem_memread    = 1'b0;
        mem_memwrite   = 1'b0;
        mem_memtoreg   = 1'b0;
        dmem_gnt       = 1'b0;
        dmem_rvalid    = 1'b0;
        dmem_rdata     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_result", wb_result, 32'h0);
        check("rst_wb_rd",     {27'h0, wb_rd}, 32'h0);
        check("rst_wb_rw",     {31'h0, wb_regwrite}, 32'h0);
        check("rst_fault",     {31'h0, mem_fault}, 32'h0);
        check("rst_stall",     {31'h0, stall}, 32'h0);
        check("rst_req",       {31'h0, dmem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        //      tag          alu           sd            rd    f3      rw    mr    mw   gw rw  rdata        req stl flt stray
        run_op("alu",       32'h0000_1234, 32'h0,        5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0,        0, 0, 0, 0);
        run_op("lb",        32'h0000_0103, 32'h0,        5'd7, 3'b000, 1'b1, 1'b1, 1'b0, 0, 0, 32'h80FF_FFFF, 1, 1, 0, 0);
        run_op("lbu",       32'h0000_0103, 32'h0,        5'd8, 3'b100, 1'b1, 1'b1, 1'b0, 0, 0, 32'h80FF_FFFF, 1, 1, 0, 0);
        run_op("lh",        32'h0000_0102, 32'h0,        5'd9, 3'b001, 1'b1, 1'b1, 1'b0, 0, 1, 32'h8001_1234, 1, 2, 0, 0);
        run_op("lhu",       32'h0000_0102, 32'h0,        5'd10, 3'b101, 1'b1, 1'b1, 1'b0, 1, 0, 32'h8001_1234, 2, 2, 0, 0);
        run_op("lw_slow",   32'h0000_0100, 32'h0,        5'd11, 3'b010, 1'b1, 1'b1, 1'b0, 2, 3, 32'hDEAD_BEEF, 3, 6, 0, 0);
        run_op("sh",        32'h0000_0202, 32'h0000_ABCD, 5'd0, 3'b001, 1'b0, 1'b0, 1'b1, 3, 0, 32'h0,        4, 3, 0, 0);
        run_op("sb",        32'h0000_0201, 32'h1234_565A, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0,        1, 0, 0, 0);
        run_op("sw",        32'h0000_0300, 32'h1234_5678, 5'd0, 3'b010, 1'b0, 1'b0, 1'b1, 1, 0, 32'h0,        2, 1, 0, 0);
        run_op("lw_mis",    32'h0000_0101, 32'h0,        5'd12, 3'b010, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0,        0, 0, 1, 0);
        run_op("alu2",      32'hCAFE_F00D, 32'h0,        5'd13, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0,        0, 0, 0, 0);
        run_op("lh_mis",    32'h0000_0203, 32'h0,        5'd14, 3'b001, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0,        0, 0, 1, 0);
        run_op("unk_mis",   32'h0000_0102, 32'h0,        5'd15, 3'b011, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0,        0, 0, 1, 0);
        run_op("lw_tmo",    32'h0000_0500, 32'h0,        5'd16, 3'b010, 1'b1, 1'b1, 1'b0, 0, -1, 32'h0,      1, TMO, 1, 0);
        run_op("late_rv",   32'h0000_55AA, 32'h0,        5'd3, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0,        0, 0, 0, 1);

        // Reset while waiting for read data.
        @(negedge clk);
        mem_alu_result = 32'h0000_0400;
        mem_rd         = 5'd9;
        mem_funct3     = 3'b010;
        mem_regwrite   = 1'b1;
        mem_memread    = 1'b1;
        mem_memwrite   = 1'b0;
        mem_memtoreg   = 1'b1;
        dmem_rvalid    = 1'b0;
        dmem_gnt       = 1'b0;
        #1;
        check("rstr_req_idle", {31'h0, dmem_req}, 32'h1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("rstr_resp_req",   {31'h0, dmem_req}, 32'h0);
        check("rstr_resp_stall", {31'h0, stall}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstr_req",       {31'h0, dmem_req}, 32'h0);
        check("rstr_stall",     {31'h0, stall}, 32'h0);
        check("rstr_wb_result", wb_result, 32'h0);
        check("rstr_wb_rd",     {27'h0, wb_rd}, 32'h0);
        check("rstr_wb_rw",     {31'h0, wb_regwrite}, 32'h0);
        check("rstr_fault",     {31'h0, mem_fault}, 32'h0);
        @(negedge clk);
        mem_memread  = 1'b0;
        mem_memtoreg = 1'b0;
        rst          = 1'b0;
        run_op("lw_after_rst", 32'h0000_0404, 32'h0, 5'd21, 3'b010, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0BAD_CAFE, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
